// File: rtl/io_hub.sv
// ---------------------------------------------------------------------------
// io_hub -- memory-mapped I/O endpoint behind the CPU byte-serial bus.
//
// Address map (mem_a[17:16] == 2'b11 selects I/O; only mem_a[17:0] decoded):
//   write, mem_a[2:0]==0 : non-zero byte pushed to the TX FIFO (0x00 ignored)
//   write, mem_a[2:0]==4 : sets the sticky program_finish flag
//   read  0x30000        : pops the RX FIFO head (0x00 when empty)
//   read  0x30004        : cycle counter byte 0, snapshots the whole counter
//   read  0x30005..7     : snapshot bytes 1..3 (coherent 32-bit read)
//   any other I/O read   : 0x00
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-low reset
//   rdy_in                CPU ready; gates bus accesses and the cycle counter
//   mem_a/mem_dout/mem_wr CPU bus address, write data, write strobe
//   io_din                registered read data (1-cycle latency)
//   io_buffer_full        TX FIFO has FULL_MARGIN or fewer free slots
//   tx_data/valid/ready   show-ahead TX FIFO output toward the UART
//   rx_data/rx_valid      UART receive bytes, one per asserted cycle
//   program_finish        sticky stop flag
//   tx_overflow           sticky: a TX byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module io_hub #(
    parameter int FIFO_WIDTH  = 3,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  io_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_finish,
    output logic        tx_overflow
);

    localparam int DEPTH = 1 << FIFO_WIDTH;

    typedef logic [FIFO_WIDTH-1:0] ptr_t;
    typedef logic [FIFO_WIDTH:0]   cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t CNT_NEAR = cnt_t'(DEPTH - FULL_MARGIN);

    localparam logic [17:0] ADDR_DATA = 18'h30000;
    localparam logic [17:0] ADDR_CNT0 = 18'h30004;
    localparam logic [17:0] ADDR_CNT1 = 18'h30005;
    localparam logic [17:0] ADDR_CNT2 = 18'h30006;
    localparam logic [17:0] ADDR_CNT3 = 18'h30007;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [17:0] io_addr;
    logic        unused_addr;
    logic        io_sel;
    logic        io_wr;
    logic        io_rd;

    assign io_addr     = mem_a[17:0];
    assign unused_addr = ^mem_a[31:18];
    assign io_sel      = rdy_in && (io_addr[17:16] == 2'b11);
    assign io_wr       = io_sel && mem_wr;
    assign io_rd       = io_sel && !mem_wr;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0] tx_mem [DEPTH];
    ptr_t       tx_wptr;
    ptr_t       tx_rptr;
    cnt_t       tx_count;
    logic       tx_wr_hit;
    logic       tx_full;
    logic       tx_push;
    logic       tx_drop;
    logic       tx_pop;

    assign tx_full        = (tx_count == CNT_FULL);
    assign tx_wr_hit      = io_wr && (io_addr[2:0] == 3'd0) && (mem_dout != 8'h00);
    assign tx_push        = tx_wr_hit && !tx_full;
    assign tx_drop        = tx_wr_hit && tx_full;
    assign tx_valid       = (tx_count != '0);
    assign tx_pop         = tx_valid && tx_ready;
    // Gated so the output is a clean zero while the FIFO is empty.
    assign tx_data        = tx_valid ? tx_mem[tx_rptr] : 8'h00;
    assign io_buffer_full = (tx_count >= CNT_NEAR);

    // NOTE: the storage array has no reset; validity is carried entirely by
    // the count, so clearing the pointers/count is enough to empty the FIFO.
    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= mem_dout;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + ptr_t'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + ptr_t'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + cnt_t'(1);
                2'b01:   tx_count <= tx_count - cnt_t'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0] rx_mem [DEPTH];
    ptr_t       rx_wptr;
    ptr_t       rx_rptr;
    cnt_t       rx_count;
    logic       rx_empty;
    logic       rx_push;
    logic       rx_pop;

    assign rx_empty = (rx_count == '0);
    // Receiver pushes are not gated by rdy_in; a full FIFO drops the byte.
    assign rx_push  = rx_valid && (rx_count != CNT_FULL);
    assign rx_pop   = io_rd && (io_addr == ADDR_DATA) && !rx_empty;

    always_ff @(posedge clk_in) begin
        if (rx_push) begin
            rx_mem[rx_wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + ptr_t'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + ptr_t'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + cnt_t'(1);
                2'b01:   rx_count <= rx_count - cnt_t'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter and coherent snapshot
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt;
    logic [31:0] snapshot;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_cnt <= '0;
            snapshot  <= '0;
        end else begin
            if (rdy_in) cycle_cnt <= cycle_cnt + 32'd1;
            // Byte 0 latches the full value so bytes 1..3 match it even
            // though the live counter keeps running between the reads.
            if (io_rd && (io_addr == ADDR_CNT0)) snapshot <= cycle_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Read data mux and registered status
    // ------------------------------------------------------------------
    logic [7:0] rd_data;

    // NOTE: rd_data gets its default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        rd_data = 8'h00;
        case (io_addr)
            ADDR_DATA: if (!rx_empty) rd_data = rx_mem[rx_rptr];
            ADDR_CNT0: rd_data = cycle_cnt[7:0];
            ADDR_CNT1: rd_data = snapshot[15:8];
            ADDR_CNT2: rd_data = snapshot[23:16];
            ADDR_CNT3: rd_data = snapshot[31:24];
            default:   ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            io_din         <= 8'h00;
            program_finish <= 1'b0;
            tx_overflow    <= 1'b0;
        end else begin
            if (io_rd) io_din <= rd_data;
            if (io_wr && (io_addr[2:0] == 3'd4)) program_finish <= 1'b1;
            if (tx_drop) tx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_hub.sv
// ---------------------------------------------------------------------------
// tb_io_hub -- self-checking bench for io_hub.
//
// The driver issues one bus/UART cycle per step and updates a queue-based
// reference model to the state expected after the coming clock edge.
// Expected TX bytes are pushed to a scoreboard queue; a monitor pops them
// whenever the DUT completes a tx_valid/tx_ready handshake.  A second
// monitor compares io_din and the status outputs after every edge.
// ---------------------------------------------------------------------------
module tb_io_hub;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic [31:0] mem_a = '0;
    logic [7:0]  mem_dout = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  io_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        program_finish;
    logic        tx_overflow;

    io_hub #(.FIFO_WIDTH(3), .FULL_MARGIN(MARGIN)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .io_din         (io_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .program_finish (program_finish),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    // Reference model: state expected after the next clock edge.
    logic [7:0]  tx_q[$];     // bytes held in the TX FIFO
    logic [7:0]  tx_out[$];   // scoreboard: bytes expected on the next handshake
    logic [7:0]  rx_q[$];     // bytes held in the RX FIFO
    logic        ovf_m  = 1'b0;
    logic        pf_m   = 1'b0;
    logic [7:0]  din_m  = 8'h00;
    logic [31:0] cnt_m  = '0;
    logic [31:0] snap_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        tx_q.delete();
        tx_out.delete();
        rx_q.delete();
        ovf_m  = 1'b0;
        pf_m   = 1'b0;
        din_m  = 8'h00;
        cnt_m  = '0;
        snap_m = '0;
    endtask

    // One cycle of stimulus, called at posedge+2; returns at the next posedge+2.
    task automatic step(input logic rdy, input logic [17:0] a, input logic wr,
                        input logic [7:0] d, input logic txr, input logic rxv,
                        input logic [7:0] rxd);
        logic [31:0] hi;
        int          tpre;
        int          rpre;
        hi   = $urandom();
        tpre = tx_q.size();
        rpre = rx_q.size();
        rdy_in   = rdy;
        mem_a    = {hi[31:18], a};
        mem_wr   = wr;
        mem_dout = d;
        tx_ready = txr;
        rx_valid = rxv;
        rx_data  = rxd;

        if (txr && tpre != 0) tx_out.push_back(tx_q.pop_front());
        if (rdy && a[17:16] == 2'b11) begin
            if (wr) begin
                if (a[2:0] == 3'd0 && d != 8'h00) begin
                    if (tpre == DEPTH) ovf_m = 1'b1;
                    else               tx_q.push_back(d);
                end
                if (a[2:0] == 3'd4) pf_m = 1'b1;
            end else begin
                case (a)
                    18'h30000: din_m = (rpre != 0) ? rx_q.pop_front() : 8'h00;
                    18'h30004: begin din_m = cnt_m[7:0]; snap_m = cnt_m; end
                    18'h30005: din_m = snap_m[15:8];
                    18'h30006: din_m = snap_m[23:16];
                    18'h30007: din_m = snap_m[31:24];
                    default:   din_m = 8'h00;
                endcase
            end
        end
        if (rdy) cnt_m = cnt_m + 32'd1;
        if (rxv && rpre < DEPTH) rx_q.push_back(rxd);

        @(posedge clk_in);
        #2;
    endtask

    task automatic wr_io(input logic [17:0] a, input logic [7:0] d, input logic txr);
        step(1'b1, a, 1'b1, d, txr, 1'b0, 8'h00);
    endtask

    task automatic rd_io(input logic [17:0] a, input logic txr);
        step(1'b1, a, 1'b0, 8'h00, txr, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n, input logic txr);
        repeat (n) step(1'b1, 18'h0, 1'b0, 8'h00, txr, 1'b0, 8'h00);
    endtask

    // Asserts reset between edges and checks the outputs clear before any edge.
    task automatic do_reset();
        rdy_in   = 1'b0;
        mem_a    = '0;
        mem_wr   = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        #1;
        rst_in = 1'b0;
        clear_model();
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_buffer_full", 32'(io_buffer_full), 32'd0);
        check("rst_io_din", 32'(io_din), 32'd0);
        check("rst_tx_overflow", 32'(tx_overflow), 32'd0);
        check("rst_program_finish", 32'(program_finish), 32'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
    endtask

    // Monitor: registered outputs after every edge.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            check("io_din", 32'(io_din), 32'(din_m));
            check("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
            check("io_buffer_full", 32'(io_buffer_full), 32'(tx_q.size() >= DEPTH - MARGIN));
            check("tx_overflow", 32'(tx_overflow), 32'(ovf_m));
            check("program_finish", 32'(program_finish), 32'(pf_m));
        end
    end

    // Monitor: TX handshakes against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clk_in);
            check("tx_handshake", 32'(tx_valid && tx_ready), 32'(tx_out.size() != 0));
            if (tx_valid && tx_ready && tx_out.size() != 0)
                check("tx_data", 32'(tx_data), 32'(tx_out.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef logic [17:0] addr_t;
    addr_t addr_tbl [12] = '{18'h30000, 18'h30000, 18'h30004, 18'h30005,
                             18'h30006, 18'h30007, 18'h30001, 18'h30003,
                             18'h30008, 18'h10000, 18'h20004, 18'h00000};

    initial begin
        // Power-on reset state.
        #1;
        check("por_io_din", 32'(io_din), 32'd0);
        check("por_tx_valid", 32'(tx_valid), 32'd0);
        check("por_tx_data", 32'(tx_data), 32'd0);
        check("por_buffer_full", 32'(io_buffer_full), 32'd0);
        check("por_program_finish", 32'(program_finish), 32'd0);
        check("por_tx_overflow", 32'(tx_overflow), 32'd0);
        @(posedge clk_in);
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;

        // Two TX bytes drained straight away.
        wr_io(18'h30000, 8'h41, 1'b1);
        wr_io(18'h30000, 8'h42, 1'b1);
        idle(3, 1'b1);

        // Fill to near-full, then full, then overflow; drain across the wrap.
        for (int i = 0; i < 9; i++) wr_io(18'h30000, 8'(8'h10 + i), 1'b0);
        check("overflow_sticky", 32'(tx_overflow), 32'd1);
        idle(10, 1'b1);

        // Zero byte is not queued; stop write is sticky.
        wr_io(18'h30000, 8'h00, 1'b1);
        idle(1, 1'b1);
        wr_io(18'h30004, 8'hAB, 1'b1);
        idle(3, 1'b1);

        // RX path, including empty read and a push coinciding with a pop.
        step(1'b1, 18'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55);
        step(1'b1, 18'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h66);
        rd_io(18'h30000, 1'b0);
        rd_io(18'h30000, 1'b0);
        rd_io(18'h30000, 1'b0);
        step(1'b1, 18'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77);
        step(1'b1, 18'h30000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h88);
        rd_io(18'h30000, 1'b0);
        rd_io(18'h30000, 1'b0);
        // rdy_in low: read is ignored but the RX push still lands.
        step(1'b0, 18'h30000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h99);
        rd_io(18'h30000, 1'b0);
        check("rx_push_while_stalled", 32'(io_din), 32'h99);

        // Counter: 300 cycles with rdy_in low for 50 gives 250.
        do_reset();
        for (int i = 0; i < 300; i++)
            step(!(i >= 100 && i < 150), 18'h0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        rd_io(18'h30004, 1'b0);
        check("cnt_byte0", 32'(io_din), 32'hFA);
        idle(3, 1'b0);
        rd_io(18'h30005, 1'b0);
        check("cnt_byte1", 32'(io_din), 32'h00);
        rd_io(18'h30006, 1'b0);
        check("cnt_byte2", 32'(io_din), 32'h00);
        rd_io(18'h30007, 1'b0);
        check("cnt_byte3", 32'(io_din), 32'h00);

        // Reset with TX bytes queued and the transmitter stalled.
        for (int i = 0; i < 7; i++) wr_io(18'h30000, 8'(8'hC0 + i), 1'b0);
        check("pre_reset_full", 32'(io_buffer_full), 32'd1);
        wr_io(18'h30004, 8'h01, 1'b0);
        do_reset();
        rd_io(18'h30004, 1'b0);
        idle(2, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            logic [7:0] d;
            logic [7:0] r;
            d = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom());
            r = 8'($urandom());
            step($urandom_range(9) < 8, addr_tbl[$urandom_range(11)],
                 1'($urandom_range(1)), d, 1'($urandom_range(1)),
                 $urandom_range(9) < 4, r);
        end
        idle(12, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
